// File: rtl/delay_scan_controller_pkg.sv
// Shared types for the detector-delay sweep controller: FSM state encoding and width defaults.
package delay_scan_controller_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_DWELL   = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/delay_scan_controller_dwell.sv
// Trigger counter for one sweep point: counts enabled triggers and pulses tc on the target-th one.
// tc is combinational so the FSM can close the point in the same cycle the last trigger arrives.
module scan_dwell_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] target,
  output logic          tc
);

  logic [CW-1:0] cnt;

  // target is never 0 here; a zero dwell is promoted to 1 when the config is latched
  assign tc = enable && (cnt == target - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tc) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/delay_scan_controller.sv
// Steps delay_det_out from start to stop, dwelling a fixed trigger count per point after one settle trigger.
// Optional SCAN_LOOP_EN adds a `loop` input that restarts the sweep from the shadowed config at completion.
module delay_scan_controller
  import delay_scan_controller_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
`ifdef SCAN_LOOP_EN
  input  logic          loop,
`endif
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_delay_start,
  input  logic [DW-1:0] cfg_delay_stop,
  input  logic [DW-1:0] cfg_delay_step,
  input  logic [CW-1:0] cfg_dwell,
  input  logic          sync_trig,
  output logic [DW-1:0] delay_det_out,
  output logic          gate,
  output logic          step_valid,
  output logic [CW-1:0] step_index,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nxt;
  logic [DW-1:0] sh_start, sh_stop, sh_step;
  logic [CW-1:0] sh_dwell;
  logic [DW-1:0] delay_q, delay_nxt;
  logic [CW-1:0] idx_q, idx_nxt;
  logic          busy_q, busy_nxt;
  logic          gate_q, gate_nxt;
  logic          sv_q, sv_nxt;
  logic          done_q, done_nxt;
  logic          latch_cfg;
  logic          dwell_tc;
  logic [DW:0]   sum;
  logic          last_point;
`ifdef SCAN_LOOP_EN
  logic          loop_q, loop_nxt;
`endif

  // The extra bit catches overflow so a sweep near the top of the range never wraps to small delays
  assign sum        = {1'b0, delay_q} + {1'b0, sh_step};
  assign last_point = (sh_step == '0) || sum[DW] || (sum[DW-1:0] > sh_stop);

  scan_dwell_counter #(.CW(CW)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != S_DWELL),
    .enable ((state == S_DWELL) && sync_trig),
    .target (sh_dwell),
    .tc     (dwell_tc)
  );

  always_comb begin
    state_nxt = state;
    delay_nxt = delay_q;
    idx_nxt   = idx_q;
    busy_nxt  = busy_q;
    gate_nxt  = gate_q;
    sv_nxt    = 1'b0;
    done_nxt  = 1'b0;
    latch_cfg = 1'b0;
`ifdef SCAN_LOOP_EN
    loop_nxt  = loop_q;
`endif
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          latch_cfg = 1'b1;
          busy_nxt  = 1'b1;
          delay_nxt = cfg_delay_start;
          idx_nxt   = '0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (sync_trig) begin
          gate_nxt  = 1'b1;
          state_nxt = S_DWELL;
        end
      end
      S_DWELL: begin
        if (dwell_tc) begin
          gate_nxt  = 1'b0;
          sv_nxt    = 1'b1;
          state_nxt = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (last_point) begin
          done_nxt  = 1'b1;
`ifdef SCAN_LOOP_EN
          busy_nxt  = loop;
          loop_nxt  = loop;
`else
          busy_nxt  = 1'b0;
`endif
          state_nxt = S_FINISH;
        end else begin
          delay_nxt = sum[DW-1:0];
          idx_nxt   = (&idx_q) ? idx_q : idx_q + CW'(1);
          state_nxt = S_LOAD;
        end
      end
      S_FINISH: begin
`ifdef SCAN_LOOP_EN
        if (loop_q) begin
          delay_nxt = sh_start;
          idx_nxt   = '0;
          state_nxt = S_LOAD;
        end else begin
          state_nxt = S_IDLE;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides everything except the delay and index, which hold their last values
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      delay_nxt = delay_q;
      idx_nxt   = idx_q;
      busy_nxt  = 1'b0;
      gate_nxt  = 1'b0;
      sv_nxt    = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      delay_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      gate_q  <= 1'b0;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      delay_q <= delay_nxt;
      idx_q   <= idx_nxt;
      busy_q  <= busy_nxt;
      gate_q  <= gate_nxt;
      sv_q    <= sv_nxt;
      done_q  <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= '0;
      sh_dwell <= '0;
    end else if (latch_cfg) begin
      sh_start <= cfg_delay_start;
      sh_stop  <= cfg_delay_stop;
      sh_step  <= cfg_delay_step;
      sh_dwell <= (cfg_dwell == '0) ? CW'(1) : cfg_dwell;
    end
  end

`ifdef SCAN_LOOP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_q <= 1'b0;
    end else begin
      loop_q <= loop_nxt;
    end
  end
`endif

  assign delay_det_out = delay_q;
  assign step_index    = idx_q;
  assign busy          = busy_q;
  assign gate          = gate_q;
  assign step_valid    = sv_q;
  assign done          = done_q;

endmodule
